mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter that shares the single-port, 14-bit-address, 32-bit-data program/data RAM between the VerySimpleCPU memory port (master 0) and a second requester (master 1: program loader / debug host). The block sits between the masters and the RAM. It grants at most one access per cycle, drives the RAM address, data and write-enable from the granted master, and routes the one-cycle-latency read data back to the master that issued the read. Ownership is sticky for bursts, with a burst limit to bound the latency seen by the other master.

## Interface
- SIZE, 14, RAM address width
- DATA_W, 32, data width
- MAX_BURST, 4, consecutive grants an owner may take while the other master waits (≥1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 resets)
- m0_req / m1_req  in  1  access request, held until granted
- m0_wr / m1_wr  in  1  1=write, 0=read
- m0_addr / m1_addr  in  SIZE  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  combinational grant; access completes at the clock edge where req&gnt
- m0_rvalid / m1_rvalid  out  1  registered, read data valid for this master
- m0_rdata / m1_rdata  out  DATA_W  ram_rdata when own rvalid=1, else 0
- ram_wrEn  out  1  RAM write enable
- ram_addr  out  SIZE  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address

## Operation
- States: IDLE, OWN0, OWN1 (registered). A burst counter cnt (saturating at MAX_BURST) and last (index of the last new owner) are also registered.
- Keep rule: in OWNx, x keeps ownership if req_x=1 and (cnt<MAX_BURST or req_other=0).
- Otherwise the block arbitrates among the asserted requests:
  - only one request asserted: that master wins;
  - both asserted: the winner follows the tie rule (Configuration).
- gnt_x = (selected==x) & req_x. At most one grant per cycle.
- Next state:
  - OWNsel if any grant, else IDLE;
  - cnt=1 on a change of owner or when leaving IDLE, cnt+1 (saturating) on a kept grant;
  - last updated on a change of owner.
- RAM outputs:
  - with a grant: mux of the granted master's wr/addr/wdata;
  - with no grant: ram_wrEn=0, ram_addr=0, ram_wdata=0.
- Read return: a granted read (wr=0) sets that master's rvalid in the next cycle only. Writes produce no rvalid.
- Reset (rst=0 at an edge):
  - state=IDLE, cnt=0, last=1 (so master 0 wins the first tie), both rvalid=0;
  - while rst=0: gnt=0, ram_wrEn=0, ram_addr=0, ram_wdata=0;
  - a read granted in the cycle before reset never returns rvalid.

## Timing
- Grant latency: 0 cycles. A request is granted in the same cycle it is raised, if the master wins.
- Ownership handover takes 0 cycles: no idle bubble between masters.
- Read latency: rvalid at cycle N+1 for a read granted at cycle N.
- Back-to-back reads by one master give rvalid on consecutive cycles.
- Worst-case wait for a master with round-robin: MAX_BURST cycles.
- If a master drops req, it loses ownership in that same cycle.
- With cnt=MAX_BURST and req_other=0, the owner continues indefinitely; cnt stays saturated.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a tie goes to the master that is not last. Burst expiry (cnt=MAX_BURST with the other master requesting) hands ownership to the other master.
- ARB_ROUND_ROBIN_EN undefined (fixed priority): a tie always goes to master 0. When master 0 hits burst expiry it re-wins immediately (cnt restarts at 1), so master 1 can starve. An owner of master 1 is preempted by master 0 on burst expiry.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, OWN0, OWN1);
  - master index constants M0=0, M1=1;
  - the default SIZE/DATA_W.
- Sub-module arb_pick: purely combinational. Inputs are req[1:0], state, cnt_expired and last; output is the selected index. It contains the keep/tie logic, including the ARB_ROUND_ROBIN_EN branch.
- The top level holds the registers, the RAM mux and the rvalid pipeline.

## Test plan
- m0 writes 0xDEADBEEF to 0x005, m1 idle → m0_gnt=1 the same cycle; ram_wrEn=1, ram_addr=0x005, ram_wdata=0xDEADBEEF; no rvalid follows.
- m1 reads 0x010 with RAM[0x010]=0x12345678, granted cycle N → m1_rvalid=1 and m1_rdata=0x12345678 at N+1; m0_rvalid=0 and m0_rdata=0 throughout.
- Both masters request continuously from reset, MAX_BURST=4:
  - with the macro: grants are m0×4, m1×4, m0×4, …;
  - without the macro: m0 holds every grant.
- m0 keeps req high for 10 cycles, m1 idle → 10 consecutive m0 grants; cnt saturates at 4; state stays OWN0.
- m0 drops req after 2 grants while m1 is waiting → m1_gnt=1 in the very next cycle, with no IDLE cycle.
- m1 read granted at N, rst=0 at the N+1 edge → m1_rvalid stays 0. After release, with both requesting, m0 is granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package mem_arb_pkg;

  localparam int SIZE_DEF   = 14;
  localparam int DATA_W_DEF = 32;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational owner selection: burst keep rule plus tie-break.
// ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise master 0 wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_state_t state,
  input  logic       cnt_expired,
  input  logic       last,
  output logic       sel
);

  logic keep0;
  logic keep1;
  logic tie;

  assign keep0 = (state == OWN0) && req[0]
               && (!cnt_expired || !req[1]);
  assign keep1 = (state == OWN1) && req[1]
               && (!cnt_expired || !req[0]);

`ifdef ARB_ROUND_ROBIN_EN
  assign tie = ~last;
`else
  logic unused_last;
  assign unused_last = last;
  assign tie = M0;
`endif

  always_comb begin
    sel = M0;
    priority case (1'b1)
      keep0:         sel = M0;
      keep1:         sel = M1;
      (&req):        sel = tie;
      req[1]:        sel = M1;
      default:       sel = M0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared single-port program/data RAM.
// Build with ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int SIZE      = SIZE_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [SIZE-1:0]   m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [SIZE-1:0]   m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_wrEn,
  output logic [SIZE-1:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  arb_state_t    state;
  arb_state_t    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          last;
  logic          last_nx;
  logic          sel;
  logic          cnt_expired;
  logic          gnt_any;
  logic          kept;
  logic          rv0;
  logic          rv1;

  assign cnt_expired = (cnt >= CMAX);

  arb_pick u_pick (
    .req         ({m1_req, m0_req}),
    .state       (state),
    .cnt_expired (cnt_expired),
    .last        (last),
    .sel         (sel)
  );

  assign m0_gnt  = rst && (sel == M0) && m0_req;
  assign m1_gnt  = rst && (sel == M1) && m1_req;
  assign gnt_any = m0_gnt || m1_gnt;

  // A kept grant is the same owner continuing, not a re-win after expiry.
  assign kept =
      (m0_gnt && state == OWN0 && !(cnt_expired && m1_req))
   || (m1_gnt && state == OWN1 && !(cnt_expired && m0_req));

  always_comb begin
    state_nx = IDLE;
    cnt_nx   = '0;
    last_nx  = last;
    if (gnt_any) begin
      state_nx = (sel == M1) ? OWN1 : OWN0;
      if (kept) begin
        cnt_nx = cnt_expired ? cnt : cnt + 1'b1;
      end else begin
        cnt_nx  = CW'(1);
        last_nx = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= M1;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
      rv0   <= m0_gnt && !m0_wr;
      rv1   <= m1_gnt && !m1_wr;
    end
  end

  always_comb begin
    ram_wrEn  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (m0_gnt) begin
      ram_wrEn  = m0_wr;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_wrEn  = m1_wr;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  // Masking with rst drops a read return that collides with reset.
  assign m0_rvalid = rv0 && rst;
  assign m1_rvalid = rv1 && rst;
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a read-return scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    int          due;
    logic        m;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [13:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_wrEn;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:16383];
  exp_t        sb[$];
  int          cyc;
  int          n_tests;
  int          n_fail;
  logic        g0, g1, rw;
  logic [13:0] ra;
  logic [31:0] rd;

  mem_arbiter #(.SIZE(14), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_wr     (m0_wr),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_wr     (m1_wr),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .ram_wrEn  (ram_wrEn),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_wrEn) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  // One cycle: sample outputs, check returns, log new reads.
  task automatic tick();
    exp_t e;
    logic have;
    logic x0, x1;
    #1;
    have = 1'b0;
    e = '{0, 1'b0, 32'h0};
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      have = rst;
    end
    x0 = have && (e.m == M0);
    x1 = have && (e.m == M1);
    n_tests++;
    if (m0_rvalid !== x0 || m0_rdata !== (x0 ? e.d : 32'h0)) begin
      n_fail++;
      $display("FAIL m0_ret cyc%0d: got v=%b d=%h expected v=%b d=%h",
               cyc, m0_rvalid, m0_rdata, x0, x0 ? e.d : 32'h0);
    end
    n_tests++;
    if (m1_rvalid !== x1 || m1_rdata !== (x1 ? e.d : 32'h0)) begin
      n_fail++;
      $display("FAIL m1_ret cyc%0d: got v=%b d=%h expected v=%b d=%h",
               cyc, m1_rvalid, m1_rdata, x1, x1 ? e.d : 32'h0);
    end
    g0 = m0_gnt; g1 = m1_gnt;
    rw = ram_wrEn; ra = ram_addr; rd = ram_wdata;
    n_tests++;
    if (g0 && g1) begin
      n_fail++;
      $display("FAIL one_gnt cyc%0d: got g0=%b g1=%b expected <=1",
               cyc, g0, g1);
    end
    if (rst && g0 && !m0_wr) sb.push_back('{cyc + 1, M0, mem[m0_addr]});
    if (rst && g1 && !m1_wr) sb.push_back('{cyc + 1, M1, mem[m1_addr]});
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0;
    m0_req = 1; m0_wr = 1; m0_addr = 14'h3; m0_wdata = 32'hA5A5A5A5;
    m1_req = 1; m1_wr = 0; m1_addr = 14'h7;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (g0 !== 0 || g1 !== 0 || rw !== 0 || ra !== 0 || rd !== 0) begin
        n_fail++;
        $display("FAIL reset_out: got g=%b%b we=%b a=%h d=%h expected all 0",
                 g0, g1, rw, ra, rd);
      end
    end
    rst = 1;
    m0_wr = 0;
    tick();
    n_tests++;
    if (g0 !== 1 || g1 !== 0) begin
      n_fail++;
      $display("FAIL reset_first_tie: got g0=%b g1=%b expected 1 0", g0, g1);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_write();
    m0_req = 1; m0_wr = 1; m0_addr = 14'h005; m0_wdata = 32'hDEADBEEF;
    tick();
    n_tests++;
    if (g0 !== 1 || rw !== 1 || ra !== 14'h005 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write: got g0=%b we=%b a=%h d=%h expected 1 1 005 deadbeef",
               g0, rw, ra, rd);
    end
    idle_inputs();
    tick();
    n_tests++;
    if (mem[5] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_mem: got %h expected deadbeef", mem[5]);
    end
    tick();
  endtask

  task automatic test_read();
    m1_req = 1; m1_wr = 0; m1_addr = 14'h010;
    tick();
    n_tests++;
    if (g1 !== 1 || g0 !== 0 || rw !== 0 || ra !== 14'h010) begin
      n_fail++;
      $display("FAIL read_gnt: got g1=%b g0=%b we=%b a=%h expected 1 0 0 010",
               g1, g0, rw, ra);
    end
    idle_inputs();
    #1;
    n_tests++;
    if (m1_rvalid !== 1 || m1_rdata !== 32'h12345678 ||
        m0_rvalid !== 0 || m0_rdata !== 0) begin
      n_fail++;
      $display("FAIL read_ret: got m1 %b/%h m0 %b/%h expected 1/12345678 0/0",
               m1_rvalid, m1_rdata, m0_rvalid, m0_rdata);
    end
    tick();
    tick();
  endtask

  task automatic test_contention();
    logic exp1;
    rst = 0;
    tick();
    rst = 1;
    m0_req = 1; m0_wr = 0;
    m1_req = 1; m1_wr = 0;
    for (int i = 0; i < 16; i++) begin
      m0_addr = 14'(i);
      m1_addr = 14'(16'h100 + i);
`ifdef ARB_ROUND_ROBIN_EN
      exp1 = ((i / 4) % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      tick();
      n_tests++;
      if (g0 !== !exp1 || g1 !== exp1) begin
        n_fail++;
        $display("FAIL contend i=%0d: got g0=%b g1=%b expected %b %b",
                 i, g0, g1, !exp1, exp1);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_saturate();
    m0_req = 1; m0_wr = 0; m0_addr = 14'h040;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (g0 !== 1) begin
        n_fail++;
        $display("FAIL sat_gnt i=%0d: got %b expected 1", i, g0);
      end
    end
    n_tests++;
    if (int'(dut.cnt) !== 4 || dut.state !== OWN0) begin
      n_fail++;
      $display("FAIL sat_state: got cnt=%0d st=%0d expected 4 %0d",
               dut.cnt, dut.state, OWN0);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_handover();
    m0_req = 1; m0_wr = 0; m0_addr = 14'h050;
    tick();
    m1_req = 1; m1_wr = 0; m1_addr = 14'h060;
    tick();
    n_tests++;
    if (g0 !== 1 || g1 !== 0) begin
      n_fail++;
      $display("FAIL hand_keep: got g0=%b g1=%b expected 1 0", g0, g1);
    end
    m0_req = 0;
    tick();
    n_tests++;
    if (g0 !== 0 || g1 !== 1) begin
      n_fail++;
      $display("FAIL hand_over: got g0=%b g1=%b expected 0 1", g0, g1);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_midread();
    m1_req = 1; m1_wr = 0; m1_addr = 14'h020;
    tick();
    n_tests++;
    if (g1 !== 1) begin
      n_fail++;
      $display("FAIL mid_gnt: got %b expected 1", g1);
    end
    rst = 0;
    m1_req = 0;
    #1;
    n_tests++;
    if (m1_rvalid !== 0 || m1_rdata !== 0) begin
      n_fail++;
      $display("FAIL mid_rvalid: got %b/%h expected 0/0", m1_rvalid, m1_rdata);
    end
    tick();
    tick();
    rst = 1;
    m0_req = 1; m0_addr = 14'h030;
    m1_req = 1; m1_addr = 14'h031;
    tick();
    n_tests++;
    if (g0 !== 1 || g1 !== 0) begin
      n_fail++;
      $display("FAIL mid_after: got g0=%b g1=%b expected 1 0", g0, g1);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 0;
    idle_inputs();
    for (int i = 0; i < 16384; i++)
      mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    mem[14'h010] = 32'h12345678;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_saturate();
    test_handover();
    test_reset_midread();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
